if_stage: RTL and testbench

- Instruction-fetch stage feeding the decode stage.
- Holds the PC and a word-addressed instruction memory, and registers the fetched word into the IF/ID latch consumed by decode.
- Takes the branch redirect that decode produces (beq_taken, imm) and a stall from the hazard logic.
- Stops fetching on a halt word.

---
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, word-addressed instruction memory and the IF/ID latch.
// Handles decode-side branch redirects, hazard stalls and halting on a halt word.
module if_stage #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                beq_taken,
   input  logic signed [31:0]  branch_imm,
   input  logic                imem_we,
   input  logic [ADDR_W-1:0]   imem_waddr,
   input  logic [31:0]         imem_wdata,
   output logic [31:0]         pc,
   output logic [31:0]         instruction,
   output logic [31:0]         id_pc,
   output logic                id_valid,
   output logic                halted,
   output logic [31:0]         fetch_count
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t state, state_next;

   logic [31:0]       imem [DEPTH];
   logic [31:0]       pc_p0;
   logic [31:0]       instr_p1;
   logic [31:0]       id_pc_p1;
   logic              vld_p1;
   logic [31:0]       fetch_count_p1;
   logic [ADDR_W-1:0] rd_idx;
   logic [31:0]       fetch_word;
   logic              redirect;
   logic              halt_hit;
   logic              advance;

   // Offset is in words; arithmetic wraps modulo 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0]        base,
                                                 input logic signed [31:0] imm);
      logic signed [31:0] ofs;
      ofs = imm <<< 2;
      return base + 32'd4 + ofs;
   endfunction

   always_ff @(posedge clk) begin
      if (imem_we) begin
         imem[imem_waddr] <= imem_wdata;
      end
   end

   assign rd_idx     = pc_p0[ADDR_W+1:2];
   assign fetch_word = imem[rd_idx];

   // A stall freezes everything, so the branch is only honoured once it drops.
   always_comb begin
      redirect = (state == RUN) && !stall && beq_taken && vld_p1;
      halt_hit = (state == RUN) && !stall && !redirect && (fetch_word == HALT_WORD);
      advance  = (state == RUN) && !stall && !redirect && !halt_hit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (halt_hit) begin
         state_next = HALT;
      end
   end

   always_comb begin
      halted = (state == HALT);
   end

   // IF -> IF/ID boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_p0          <= RESET_PC;
         instr_p1       <= 32'h0;
         id_pc_p1       <= 32'h0;
         vld_p1         <= 1'b0;
         fetch_count_p1 <= 32'h0;
      end else if (!stall) begin
         if (redirect) begin
            pc_p0 <= branch_target(id_pc_p1, branch_imm);
         end else if (advance) begin
            pc_p0 <= pc_p0 + 32'd4;
         end

         if (advance) begin
            instr_p1       <= fetch_word;
            id_pc_p1       <= pc_p0;
            vld_p1         <= 1'b1;
            fetch_count_p1 <= fetch_count_p1 + 32'd1;
         end else begin
            instr_p1 <= 32'h0;
            vld_p1   <= 1'b0;
         end
      end
   end

   assign pc          = pc_p0;
   assign instruction = instr_p1;
   assign id_pc       = id_pc_p1;
   assign id_valid    = vld_p1;
   assign fetch_count = fetch_count_p1;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table-driven per-edge vectors checked through an expectation queue,
// plus hand-written reset, same-cycle write and halt sequences.
module tb_if_stage;

   logic               clk;
   logic               reset;
   logic               stall;
   logic               beq_taken;
   logic signed [31:0] branch_imm;
   logic               imem_we;
   logic [7:0]         imem_waddr;
   logic [31:0]        imem_wdata;
   logic [31:0]        pc;
   logic [31:0]        instruction;
   logic [31:0]        id_pc;
   logic               id_valid;
   logic               halted;
   logic [31:0]        fetch_count;

   int total_checks;
   int passed_checks;

   typedef struct {
      logic        stall;
      logic        beq;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] id_pc;
      logic        chk_id;
      logic        vld;
      logic        halted;
      logic [31:0] cnt;
   } vec_t;

   vec_t exp_q[$];
   vec_t va[10];
   vec_t vb[7];
   vec_t vc[6];
   vec_t vd[2];

   if_stage #(
      .ADDR_W   (8),
      .RESET_PC (32'h0000_0000),
      .HALT_WORD(32'hFFFF_FFFF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .beq_taken  (beq_taken),
      .branch_imm (branch_imm),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .pc         (pc),
      .instruction(instruction),
      .id_pc      (id_pc),
      .id_valid   (id_valid),
      .halted     (halted),
      .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic vec_t mk(input logic s, input logic b, input logic [31:0] imm,
                               input logic [31:0] p, input logic [31:0] ins,
                               input logic [31:0] ip, input logic ci, input logic v,
                               input logic h, input logic [31:0] c);
      vec_t r;
      r.stall = s;  r.beq = b;     r.imm = imm;
      r.pc    = p;  r.instr = ins; r.id_pc = ip;
      r.chk_id = ci; r.vld = v;    r.halted = h; r.cnt = c;
      return r;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         passed_checks++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      cmp({tag, ".pc"},          pc,                  32'h0);
      cmp({tag, ".instruction"}, instruction,         32'h0);
      cmp({tag, ".id_pc"},       id_pc,               32'h0);
      cmp({tag, ".id_valid"},    {31'h0, id_valid},   32'h0);
      cmp({tag, ".halted"},      {31'h0, halted},     32'h0);
      cmp({tag, ".fetch_count"}, fetch_count,         32'h0);
   endtask

   // Called just after a falling edge; returns just after the following falling edge.
   task automatic run_vec(input vec_t v, input string tag);
      vec_t e;
      stall      = v.stall;
      beq_taken  = v.beq;
      branch_imm = v.imm;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      cmp({tag, ".pc"},          pc,                 e.pc);
      cmp({tag, ".instruction"}, instruction,        e.instr);
      if (e.chk_id) cmp({tag, ".id_pc"}, id_pc, e.id_pc);
      cmp({tag, ".id_valid"},    {31'h0, id_valid},  {31'h0, e.vld});
      cmp({tag, ".halted"},      {31'h0, halted},    {31'h0, e.halted});
      cmp({tag, ".fetch_count"}, fetch_count,        e.cnt);
      @(negedge clk);
   endtask

   task automatic load(input logic [7:0] a, input logic [31:0] d);
      imem_we    = 1'b1;
      imem_waddr = a;
      imem_wdata = d;
      @(posedge clk);
      @(negedge clk);
      imem_we = 1'b0;
   endtask

   task automatic async_reset_mid_cycle(input string tag);
      #2 reset = 1'b0;
      #1 check_reset_values(tag);
      @(negedge clk);
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;
      reset      = 1'b0;
      stall      = 1'b0;
      beq_taken  = 1'b0;
      branch_imm = '0;
      imem_we    = 1'b0;
      imem_waddr = '0;
      imem_wdata = '0;

      va[0] = mk(0,0,0, 32'd4,  32'h0022_1820, 32'd0,  1,1,0, 32'd1);
      va[1] = mk(0,0,0, 32'd8,  32'h8C04_0008, 32'd4,  1,1,0, 32'd2);
      va[2] = mk(1,0,0, 32'd8,  32'h8C04_0008, 32'd4,  1,1,0, 32'd2);
      va[3] = mk(1,0,0, 32'd8,  32'h8C04_0008, 32'd4,  1,1,0, 32'd2);
      va[4] = mk(0,0,0, 32'd12, 32'hAC04_0010, 32'd8,  1,1,0, 32'd3);
      va[5] = mk(0,0,0, 32'd16, 32'h0000_0000, 32'd12, 1,1,0, 32'd4);
      va[6] = mk(0,0,0, 32'd20, 32'h2000_0004, 32'd16, 1,1,0, 32'd5);
      va[7] = mk(0,0,0, 32'd24, 32'h2000_0005, 32'd20, 1,1,0, 32'd6);
      va[8] = mk(0,0,0, 32'd28, 32'h2000_0006, 32'd24, 1,1,0, 32'd7);
      va[9] = mk(0,0,0, 32'h20, 32'h2000_0007, 32'd28, 1,1,0, 32'd8);

      vb[0] = mk(0,0,0,             32'd4,  32'h0022_1820, 32'd0,  1,1,0, 32'd1);
      vb[1] = mk(0,0,0,             32'd8,  32'h1020_0003, 32'd4,  1,1,0, 32'd2);
      vb[2] = mk(1,1,32'd3,         32'd8,  32'h1020_0003, 32'd4,  1,1,0, 32'd2);
      vb[3] = mk(0,1,32'd3,         32'h14, 32'h0,         32'd0,  0,0,0, 32'd2);
      vb[4] = mk(0,1,32'd3,         32'h18, 32'h2000_0005, 32'h14, 1,1,0, 32'd3);
      vb[5] = mk(0,1,32'hFFFF_FFFE, 32'h10, 32'h0,         32'd0,  0,0,0, 32'd3);
      vb[6] = mk(0,0,0,             32'h14, 32'h2000_0004, 32'h10, 1,1,0, 32'd4);

      vc[0] = mk(0,0,0,     32'd4, 32'h0022_1820, 32'd0, 1,1,0, 32'd1);
      vc[1] = mk(0,0,0,     32'd8, 32'h1020_0003, 32'd4, 1,1,0, 32'd2);
      vc[2] = mk(0,0,0,     32'd8, 32'h0,         32'd0, 0,0,1, 32'd2);
      vc[3] = mk(0,1,32'd3, 32'd8, 32'h0,         32'd0, 0,0,1, 32'd2);
      vc[4] = mk(1,0,0,     32'd8, 32'h0,         32'd0, 0,0,1, 32'd2);
      vc[5] = mk(0,0,0,     32'd8, 32'h0,         32'd0, 0,0,1, 32'd2);

      vd[0] = mk(0,0,0, 32'd4, 32'h0022_1820, 32'd0, 1,1,0, 32'd1);
      vd[1] = mk(0,0,0, 32'd8, 32'h1234_5678, 32'd4, 1,1,0, 32'd2);

      @(negedge clk);
      check_reset_values("reset_initial");

      for (int i = 0; i < 256; i++) load(i[7:0], 32'h2000_0000 | 32'(i));
      load(8'd0, 32'h0022_1820);
      load(8'd1, 32'h8C04_0008);
      load(8'd2, 32'hAC04_0010);
      load(8'd3, 32'h0000_0000);
      check_reset_values("reset_held");

      reset = 1'b1;
      for (int i = 0; i < 10; i++) run_vec(va[i], $sformatf("seq_stall[%0d]", i));

      // Asynchronous reset while pc = 0x20, then a branch program.
      async_reset_mid_cycle("reset_midrun");
      load(8'd1, 32'h1020_0003);
      reset = 1'b1;
      for (int i = 0; i < 7; i++) run_vec(vb[i], $sformatf("branch[%0d]", i));

      // Halt program; the fetch of word 1 coincides with a write to the same index.
      async_reset_mid_cycle("reset_before_halt");
      load(8'd2, 32'hFFFF_FFFF);
      reset = 1'b1;
      run_vec(vc[0], "halt[0]");
      imem_we    = 1'b1;
      imem_waddr = 8'd1;
      imem_wdata = 32'h1234_5678;
      run_vec(vc[1], "halt[1]_wr_same_idx");
      imem_we = 1'b0;
      for (int i = 2; i < 6; i++) run_vec(vc[i], $sformatf("halt[%0d]", i));

      // Reset is the only exit from HALT; memory (including the late write) survives it.
      async_reset_mid_cycle("reset_from_halt");
      reset = 1'b1;
      for (int i = 0; i < 2; i++) run_vec(vd[i], $sformatf("refetch[%0d]", i));

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
